// File: rtl/vga_pattern_source_if.sv
// Video bundle between the pattern source and its consumer.
// Control inputs, pixel/sync outputs and the coordinate side-band.
interface vga_pattern_source_if #(
   parameter int PRECISION  = 11,
   parameter int PIXEL_SIZE = 16
);
   logic                  enable;
   logic [1:0]            pattern_sel;
   logic [PIXEL_SIZE-1:0] solid_colour;
   logic [PIXEL_SIZE-1:0] rgb_out;
   logic                  hsync_out;
   logic                  vsync_out;
   logic                  de_out;
   logic [PRECISION-1:0]  pixel_x;
   logic [PRECISION-1:0]  pixel_y;
   logic                  frame_start;
   logic [7:0]            frame_count;

   modport master (
      input  enable,
      input  pattern_sel,
      input  solid_colour,
      output rgb_out,
      output hsync_out,
      output vsync_out,
      output de_out,
      output pixel_x,
      output pixel_y,
      output frame_start,
      output frame_count
   );

   modport slave (
      output enable,
      output pattern_sel,
      output solid_colour,
      input  rgb_out,
      input  hsync_out,
      input  vsync_out,
      input  de_out,
      input  pixel_x,
      input  pixel_y,
      input  frame_start,
      input  frame_count
   );
endinterface

// File: rtl/vga_pattern_source.sv
// SVGA timing generator and RGB565 test-pattern transmitter.
// Outputs are registered and describe the counter position before each edge.
module vga_pattern_source #(
   parameter int PRECISION     = 11,
   parameter int PIXEL_SIZE    = 16,
   parameter int X_RES         = 800,
   parameter int Y_RES         = 600,
   parameter int H_FRONT_PORCH = 40,
   parameter int H_SYNC        = 128,
   parameter int H_BACK_PORCH  = 88,
   parameter int V_FRONT_PORCH = 1,
   parameter int V_SYNC        = 4,
   parameter int V_BACK_PORCH  = 23,
   parameter int HSYNC_POL     = 1,
   parameter int VSYNC_POL     = 1
) (
   input logic                clk,
   input logic                rst,
   vga_pattern_source_if.master vid
);

   localparam int H_TOTAL = X_RES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
   localparam int V_TOTAL = Y_RES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
   localparam int BAR_W   = X_RES / 8;

   localparam logic [PRECISION-1:0] H_LAST   = PRECISION'(H_TOTAL - 1);
   localparam logic [PRECISION-1:0] V_LAST   = PRECISION'(V_TOTAL - 1);
   localparam logic [PRECISION-1:0] H_ACT    = PRECISION'(X_RES);
   localparam logic [PRECISION-1:0] V_ACT    = PRECISION'(Y_RES);
   localparam logic [PRECISION-1:0] HS_BEG   = PRECISION'(X_RES + H_FRONT_PORCH);
   localparam logic [PRECISION-1:0] HS_END   = PRECISION'(X_RES + H_FRONT_PORCH + H_SYNC);
   localparam logic [PRECISION-1:0] VS_BEG   = PRECISION'(Y_RES + V_FRONT_PORCH);
   localparam logic [PRECISION-1:0] VS_END   = PRECISION'(Y_RES + V_FRONT_PORCH + V_SYNC);
   localparam logic [PRECISION-1:0] BAR_LAST = PRECISION'(BAR_W - 1);

   localparam logic HS_ON = (HSYNC_POL != 0);
   localparam logic VS_ON = (VSYNC_POL != 0);

   generate
      if (H_TOTAL >= (1 << PRECISION) || V_TOTAL >= (1 << PRECISION)) begin : g_size_check
         $error("vga_pattern_source: totals do not fit in PRECISION bits");
      end
   endgenerate

   logic [PRECISION-1:0]  h_cnt;
   logic [PRECISION-1:0]  v_cnt;
   logic [PRECISION-1:0]  bar_cnt;
   logic [2:0]            bar_idx;
   logic [1:0]            pat_q;
   logic [PIXEL_SIZE-1:0] col_q;

   logic                  origin;
   logic                  active;
   logic                  h_last;
   logic                  hs_act;
   logic                  vs_act;
   logic [1:0]            pat;
   logic [PIXEL_SIZE-1:0] col;
   logic [PIXEL_SIZE-1:0] bar_col;
   logic [PIXEL_SIZE-1:0] pix;

   // Pattern and colour are taken live at (0,0) so the first pixel already uses them.
   always_comb begin
      origin = (h_cnt == '0) && (v_cnt == '0);
      active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      h_last = (h_cnt == H_LAST);
      hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      pat    = origin ? vid.pattern_sel : pat_q;
      col    = origin ? vid.solid_colour : col_q;
   end

   always_comb begin
      bar_col = '0;
      unique case (bar_idx)
         3'd0: bar_col = PIXEL_SIZE'(16'hFFFF);
         3'd1: bar_col = PIXEL_SIZE'(16'hFFE0);
         3'd2: bar_col = PIXEL_SIZE'(16'h07FF);
         3'd3: bar_col = PIXEL_SIZE'(16'h07E0);
         3'd4: bar_col = PIXEL_SIZE'(16'hF81F);
         3'd5: bar_col = PIXEL_SIZE'(16'hF800);
         3'd6: bar_col = PIXEL_SIZE'(16'h001F);
         3'd7: bar_col = PIXEL_SIZE'(16'h0000);
      endcase
   end

   always_comb begin
      pix = '0;
      unique case (pat)
         2'd0: pix = col;
         2'd1: pix = bar_col;
         2'd2: pix = (h_cnt[4] ^ v_cnt[4]) ? '0 : '1;
         2'd3: pix = PIXEL_SIZE'({h_cnt[7:3], h_cnt[7:2], h_cnt[7:3]});
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !vid.enable) begin
         h_cnt           <= '0;
         v_cnt           <= '0;
         bar_cnt         <= '0;
         bar_idx         <= '0;
         vid.rgb_out     <= '0;
         vid.hsync_out   <= ~HS_ON;
         vid.vsync_out   <= ~VS_ON;
         vid.de_out      <= 1'b0;
         vid.pixel_x     <= '0;
         vid.pixel_y     <= '0;
         vid.frame_start <= 1'b0;
         if (rst) begin
            vid.frame_count <= '0;
            pat_q           <= '0;
            col_q           <= '0;
         end
      end else begin
         vid.de_out      <= active;
         vid.rgb_out     <= active ? pix : '0;
         vid.pixel_x     <= active ? h_cnt : '0;
         vid.pixel_y     <= active ? v_cnt : '0;
         vid.hsync_out   <= hs_act ? HS_ON : ~HS_ON;
         vid.vsync_out   <= vs_act ? VS_ON : ~VS_ON;
         vid.frame_start <= origin;
         if (origin) begin
            vid.frame_count <= vid.frame_count + 8'd1;
            pat_q           <= vid.pattern_sel;
            col_q           <= vid.solid_colour;
         end
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         // Bar index advances by counting pixels within the bar, avoiding a divider.
         if (h_last) begin
            bar_cnt <= '0;
            bar_idx <= '0;
         end else if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_cnt <= bar_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_source.sv
// Scoreboard bench for vga_pattern_source on a reduced raster.
// A behavioural model predicts every edge; a monitor compares after it.
module tb_vga_pattern_source;

   localparam int P   = 11;
   localparam int PS  = 16;
   localparam int XR  = 40;
   localparam int YR  = 20;
   localparam int HFP = 2;
   localparam int HSW = 4;
   localparam int HBP = 2;
   localparam int VFP = 1;
   localparam int VSW = 2;
   localparam int VBP = 1;
   localparam int HT  = XR + HFP + HSW + HBP;
   localparam int VT  = YR + VFP + VSW + VBP;
   localparam int BW  = XR / 8;

   logic clk = 1'b0;
   logic rst;

   vga_pattern_source_if #(.PRECISION(P), .PIXEL_SIZE(PS)) vid ();

   vga_pattern_source #(
      .PRECISION(P), .PIXEL_SIZE(PS),
      .X_RES(XR), .Y_RES(YR),
      .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_BACK_PORCH(HBP),
      .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_BACK_PORCH(VBP),
      .HSYNC_POL(1), .VSYNC_POL(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vid(vid.master)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [63:0] sb[$];

   int mh, mv, mpat;
   logic [15:0] mcol;
   logic [7:0]  mfc;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack(logic [15:0] rgb, logic hs, logic vs,
                                        logic de, int px, int py, logic fs,
                                        logic [7:0] fc);
      return {14'd0, rgb, hs, vs, de, P'(px), P'(py), fs, fc};
   endfunction

   function automatic logic [15:0] bar_colour(int i);
      case (i)
         0: return 16'hFFFF;
         1: return 16'hFFE0;
         2: return 16'h07FF;
         3: return 16'h07E0;
         4: return 16'hF81F;
         5: return 16'hF800;
         6: return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   // Predict what the next edge must produce, then advance the model.
   task automatic model_push();
      logic [15:0] rgb;
      logic act, hs, vs, fs;
      int r5, g6;
      if (rst || !vid.enable) begin
         if (rst) begin
            mfc = 8'd0;
            mpat = 0;
            mcol = 16'h0;
         end
         sb.push_back(pack(16'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, mfc));
         mh = 0;
         mv = 0;
      end else begin
         fs = (mh == 0 && mv == 0);
         if (fs) begin
            mpat = int'(vid.pattern_sel);
            mcol = vid.solid_colour;
            mfc = mfc + 8'd1;
         end
         act = (mh < XR) && (mv < YR);
         case (mpat)
            0: rgb = mcol;
            1: rgb = bar_colour(mh / BW);
            2: rgb = (((mh / 16) % 2) != ((mv / 16) % 2)) ? 16'h0000 : 16'hFFFF;
            default: begin
               r5 = (mh / 8) % 32;
               g6 = (mh / 4) % 64;
               rgb = {r5[4:0], g6[5:0], r5[4:0]};
            end
         endcase
         hs = (mh >= XR + HFP) && (mh < XR + HFP + HSW);
         vs = (mv >= YR + VFP) && (mv < YR + VFP + VSW);
         sb.push_back(pack(act ? rgb : 16'h0, hs, vs, act,
                           act ? mh : 0, act ? mv : 0, fs, mfc));
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
         end
      end
   endtask

   task automatic tick();
      model_push();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      logic [63:0] exp;
      #1;
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         check("sb", pack(vid.rgb_out, vid.hsync_out, vid.vsync_out,
                          vid.de_out, int'(vid.pixel_x), int'(vid.pixel_y),
                          vid.frame_start, vid.frame_count), exp);
      end
   end

   initial begin
      logic [7:0] fc_save;
      rst = 1'b1;
      vid.enable = 1'b1;
      vid.pattern_sel = 2'd0;
      vid.solid_colour = 16'hF800;
      mh = 0;
      mv = 0;
      mpat = 0;
      mcol = 16'h0;
      mfc = 8'd0;
      repeat (3) tick();
      check("rst_de", 64'(vid.de_out), 64'd0);
      check("rst_rgb", 64'(vid.rgb_out), 64'd0);
      check("rst_fc", 64'(vid.frame_count), 64'd0);
      check("rst_sync", 64'({vid.hsync_out, vid.vsync_out}), 64'd0);

      rst = 1'b0;
      tick();
      check("first_de", 64'(vid.de_out), 64'd1);
      check("first_xy", 64'({vid.pixel_x, vid.pixel_y}), 64'd0);
      check("first_fs", 64'(vid.frame_start), 64'd1);
      check("first_fc", 64'(vid.frame_count), 64'd1);

      // Mid-frame switch to checker must not tear the solid frame.
      for (int i = 0; i < HT * VT && mv != YR / 2; i++) tick();
      vid.pattern_sel = 2'd2;
      vid.solid_colour = 16'h001F;
      for (int i = 0; i < HT * VT && !(mh == 0 && mv == 0); i++) tick();
      repeat (HT * VT / 2) tick();
      vid.pattern_sel = 2'd1;
      repeat (HT * VT) tick();
      vid.pattern_sel = 2'd3;
      repeat (HT * VT) tick();

      for (int i = 0; i < HT * VT && !(mv == 5 && mh == XR / 2); i++) tick();
      fc_save = vid.frame_count;
      vid.enable = 1'b0;
      tick();
      check("dis_de", 64'(vid.de_out), 64'd0);
      check("dis_rgb", 64'(vid.rgb_out), 64'd0);
      check("dis_fc", 64'(vid.frame_count), 64'(fc_save));
      vid.enable = 1'b1;
      tick();
      check("re_fs", 64'(vid.frame_start), 64'd1);
      check("re_xy", 64'({vid.pixel_x, vid.pixel_y}), 64'd0);
      repeat (2 * HT) tick();

      // Each re-enable starts a frame, so 256 restarts wrap the counter.
      fc_save = vid.frame_count;
      for (int i = 0; i < 256; i++) begin
         vid.enable = 1'b0;
         tick();
         vid.enable = 1'b1;
         tick();
      end
      check("fc_wrap", 64'(vid.frame_count), 64'(fc_save));

      rst = 1'b1;
      tick();
      check("rst2_fc", 64'(vid.frame_count), 64'd0);
      rst = 1'b0;
      repeat (HT) tick();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
